// File: rtl/counter_host_pkg.sv
// -----------------------------------------------------------------------------
// counter_host_pkg
// Shared types and constants for the counter host block.
//   op_e     : command opcodes carried on i_cmd_op
//   state_e  : host sequencing states
//   SETUP_*  : encodings driven on o_setup toward the counter
// -----------------------------------------------------------------------------
package counter_host_pkg;

    typedef enum logic [1:0] {
        OP_READ     = 2'b00,
        OP_RESTART  = 2'b01,
        OP_LOAD_INC = 2'b10,
        OP_LOAD_DEC = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RESTART = 3'd2,
        ST_READ    = 3'd3,
        ST_RSP     = 3'd4
    } state_e;

    localparam logic [1:0] SETUP_COUNT = 2'b00;
    localparam logic [1:0] SETUP_INC   = 2'b10;
    localparam logic [1:0] SETUP_DEC   = 2'b11;

    // Both load opcodes have the MSB set; that bit is what marks a load.
    function automatic logic is_load_op(input op_e op);
        return (op == OP_LOAD_INC) || (op == OP_LOAD_DEC);
    endfunction

endpackage

// File: rtl/counter_host_match_cnt.sv
// -----------------------------------------------------------------------------
// counter_host_match_cnt
// Saturating event counter with synchronous clear. Clear has priority over
// an increment in the same cycle.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_clr    clear the count to zero
//   i_inc    count one event this cycle
//   o_cnt    current count, holds at all-ones
// -----------------------------------------------------------------------------
module counter_host_match_cnt
    import counter_host_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = (r_cnt == {W{1'b1}});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/counter_host.sv
// -----------------------------------------------------------------------------
// counter_host
// Bus-side initiator for one programmable counter on a shared tristate value
// bus. Converts valid/ready commands into o_setup / o_restart / io_value
// cycles and returns read samples on a valid/ready response channel.
//
// Optional feature macro: COUNTER_HOST_MATCH_CNT_EN
//   defined   : o_match_cnt present, counts i_match cycles (saturating),
//               cleared by any accepted load command
//   undefined : no o_match_cnt port, i_match ignored
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready   command handshake
//   i_cmd_op                  00 read, 01 restart, 10 load-inc, 11 load-dec
//   i_cmd_data                load value (ignored for read/restart)
//   o_rsp_valid/i_rsp_ready   read response handshake
//   o_rsp_data                sampled counter value
//   io_value                  shared value bus
//   o_setup                   counter setup code (00 count, 10 inc, 11 dec)
//   o_restart                 one-cycle restart pulse
//   i_match                   counter match flag
//   o_match_cnt               match event count (macro only)
//
// State   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a command
// LOAD    | o_setup = load code, host drives io_value with load value
// RESTART | o_restart pulse to the counter
// READ    | counter owns the bus, sample taken at the closing edge
// RSP     | response held until the consumer takes it
// -----------------------------------------------------------------------------
module counter_host
    import counter_host_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MCNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [WIDTH-1:0]  i_cmd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [WIDTH-1:0]  o_rsp_data,
    inout  wire  [WIDTH-1:0]  io_value,
    output logic [1:0]        o_setup,
    output logic              o_restart,
    input  logic              i_match
`ifdef COUNTER_HOST_MATCH_CNT_EN
    ,
    output logic [MCNT_W-1:0] o_match_cnt
`endif
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_cmd_ready;
    logic              w_cmd_ready_nxt;
    logic [1:0]        r_setup;
    logic [1:0]        w_setup_nxt;
    logic              r_restart;
    logic              w_restart_nxt;
    logic [WIDTH-1:0]  r_drive_val;
    logic [WIDTH-1:0]  w_drive_val_nxt;
    logic              r_rsp_valid;
    logic              w_rsp_valid_nxt;
    logic [WIDTH-1:0]  r_rsp_data;
    logic [WIDTH-1:0]  w_rsp_data_nxt;

    op_e               w_op;
    logic              w_accept;
    logic              w_drive_en;

    assign w_op     = op_e'(i_cmd_op);
    // r_cmd_ready is only ever set on entry to IDLE, so it doubles as the
    // IDLE qualifier for the handshake.
    assign w_accept = i_cmd_valid && r_cmd_ready;

    // Bus direction is derived from the same flop as o_setup: the host drives
    // exactly while a load code is presented and releases on the edge where
    // o_setup returns to count, which is when the counter may drive again.
    assign w_drive_en = (r_setup != SETUP_COUNT);
    assign io_value   = w_drive_en ? r_drive_val : {WIDTH{1'bz}};

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = 1'b0;
        w_setup_nxt     = SETUP_COUNT;
        w_restart_nxt   = 1'b0;
        w_drive_val_nxt = r_drive_val;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_cmd_ready_nxt = 1'b0;
                    case (w_op)
                        OP_READ: begin
                            w_state_nxt = ST_READ;
                        end
                        OP_RESTART: begin
                            w_state_nxt   = ST_RESTART;
                            w_restart_nxt = 1'b1;
                        end
                        OP_LOAD_INC: begin
                            w_state_nxt     = ST_LOAD;
                            w_setup_nxt     = SETUP_INC;
                            w_drive_val_nxt = i_cmd_data;
                        end
                        OP_LOAD_DEC: begin
                            w_state_nxt     = ST_LOAD;
                            w_setup_nxt     = SETUP_DEC;
                            w_drive_val_nxt = i_cmd_data;
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_ready_nxt = 1'b1;
            end

            ST_RESTART: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_ready_nxt = 1'b1;
            end

            ST_READ: begin
                // Counter is driving the bus during this cycle.
                w_state_nxt     = ST_RSP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = io_value;
            end

            ST_RSP: begin
                if (i_rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_setup     <= SETUP_COUNT;
            r_restart   <= 1'b0;
            r_drive_val <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_setup     <= w_setup_nxt;
            r_restart   <= w_restart_nxt;
            r_drive_val <= w_drive_val_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_setup     = r_setup;
    assign o_restart   = r_restart;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;

`ifdef COUNTER_HOST_MATCH_CNT_EN
    logic w_match_clr;

    assign w_match_clr = w_accept && is_load_op(w_op);

    counter_host_match_cnt #(
        .W (MCNT_W)
    ) u_match_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_match_clr),
        .i_inc   (i_match),
        .o_cnt   (o_match_cnt)
    );
`else
    logic              w_unused_match;
    logic [MCNT_W-1:0] w_unused_mcnt;

    assign w_unused_match = i_match;
    assign w_unused_mcnt  = '0;
`endif

endmodule

// File: tb/tb_counter_host.sv
// -----------------------------------------------------------------------------
// tb_counter_host
// Pairs counter_host with a small behavioural counter on the shared bus.
// The counter model only advances on cycles where the bench raises r_step,
// which keeps every read value predictable by hand.
// -----------------------------------------------------------------------------
module tb_counter_host;

    localparam int WIDTH = 16;
`ifdef COUNTER_HOST_MATCH_CNT_EN
    localparam int MCNT_W = 2;
`else
    localparam int MCNT_W = 8;
`endif

    logic              i_clk;
    logic              i_rst_n;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [1:0]        i_cmd_op;
    logic [WIDTH-1:0]  i_cmd_data;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [WIDTH-1:0]  o_rsp_data;
    wire  [WIDTH-1:0]  io_value;
    logic [1:0]        o_setup;
    logic              o_restart;
    logic              i_match;
`ifdef COUNTER_HOST_MATCH_CNT_EN
    logic [MCNT_W-1:0] o_match_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    counter_host #(
        .WIDTH  (WIDTH),
        .MCNT_W (MCNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_data  (i_cmd_data),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .io_value    (io_value),
        .o_setup     (o_setup),
        .o_restart   (o_restart),
        .i_match     (i_match)
`ifdef COUNTER_HOST_MATCH_CNT_EN
        ,
        .o_match_cnt (o_match_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural counter: load-inc starts at 0 counting up to the limit,
    // load-dec starts at the limit counting down; both wrap. It drives the
    // bus only in count mode and out of reset.
    logic [WIDTH-1:0] c_cnt;
    logic [WIDTH-1:0] c_lim;
    logic             c_up;
    logic             r_step;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c_cnt <= '0;
            c_lim <= '0;
            c_up  <= 1'b1;
        end else if (o_setup == 2'b10) begin
            c_lim <= io_value;
            c_up  <= 1'b1;
            c_cnt <= '0;
        end else if (o_setup == 2'b11) begin
            c_lim <= io_value;
            c_up  <= 1'b0;
            c_cnt <= io_value;
        end else if (o_restart) begin
            c_cnt <= c_up ? '0 : c_lim;
        end else if (r_step) begin
            if (c_up) c_cnt <= (c_cnt == c_lim) ? '0 : c_cnt + 1'b1;
            else      c_cnt <= (c_cnt == '0) ? c_lim : c_cnt - 1'b1;
        end
    end

    assign io_value = (i_rst_n && o_setup == 2'b00) ? c_cnt : {WIDTH{1'bz}};
    assign i_match  = c_up && ({16'd0, c_cnt} == {16'd0, c_lim} - 32'd1);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic step();
        r_step = 1'b1;
        tick();
        r_step = 1'b0;
    endtask

    // Returns just after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data);
        int waited;
        waited      = 0;
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_data  = data;
        while (!o_cmd_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("cmd_ready_wait", {31'd0, o_cmd_ready}, 32'd1);
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [WIDTH-1:0] exp);
        send_cmd(2'b00, 16'hDEAD);
        chk({tag, "_rdy_low"}, {31'd0, o_cmd_ready}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, o_rsp_valid}, 32'd1);
        chk({tag, "_data"}, {16'd0, o_rsp_data}, {16'd0, exp});
        chk({tag, "_bus_known"}, {31'd0, $isunknown(io_value)}, 32'd0);
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        chk({tag, "_valid_clr"}, {31'd0, o_rsp_valid}, 32'd0);
    endtask

    task automatic do_load(input logic [1:0] op, input logic [WIDTH-1:0] val);
        send_cmd(op, val);
        chk("load_setup", {30'd0, o_setup}, {30'd0, op});
        chk("load_bus", {16'd0, io_value}, {16'd0, val});
        chk("load_rdy_low", {31'd0, o_cmd_ready}, 32'd0);
        tick();
        chk("load_setup_ret", {30'd0, o_setup}, 32'd0);
        chk("load_rdy_back", {31'd0, o_cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'b00;
        i_cmd_data  = '0;
        i_rsp_ready = 1'b0;
        r_step      = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        chk("rst_setup", {30'd0, o_setup}, 32'd0);
        chk("rst_restart", {31'd0, o_restart}, 32'd0);
        chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, o_rsp_data}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // load-inc 5: values 0..5 then wrap, match at 4
        do_load(2'b10, 16'd5);
        do_read("inc_v0", 16'd0);
        for (int v = 1; v <= 5; v++) begin
            step();
            do_read("inc_step", v[15:0]);
            if (v == 4) chk("inc_match_at4", {31'd0, i_match}, 32'd1);
            if (v == 5) chk("inc_nomatch_at5", {31'd0, i_match}, 32'd0);
        end
        step();
        do_read("inc_wrap", 16'd0);

        // load-dec 3: 3,2,1,0,3
        do_load(2'b11, 16'd3);
        do_read("dec_v3", 16'd3);
        step(); do_read("dec_v2", 16'd2);
        step(); do_read("dec_v1", 16'd1);
        step(); do_read("dec_v0", 16'd0);
        step(); do_read("dec_wrap", 16'd3);

        // restart at value 7 of 10
        do_load(2'b10, 16'd10);
        repeat (7) step();
        do_read("rs_v7", 16'd7);
        send_cmd(2'b01, 16'hFFFF);
        chk("rs_pulse", {31'd0, o_restart}, 32'd1);
        chk("rs_setup", {30'd0, o_setup}, 32'd0);
        chk("rs_rdy_low", {31'd0, o_cmd_ready}, 32'd0);
        tick();
        chk("rs_pulse_end", {31'd0, o_restart}, 32'd0);
        chk("rs_rdy_back", {31'd0, o_cmd_ready}, 32'd1);
        do_read("rs_after", 16'd0);

        // response back-pressure with a pending load
        step(); step();
        send_cmd(2'b00, 16'd0);
        tick();
        chk("bp_valid0", {31'd0, o_rsp_valid}, 32'd1);
        chk("bp_data0", {16'd0, o_rsp_data}, 32'd2);
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'b10;
        i_cmd_data  = 16'd2;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_valid", {31'd0, o_rsp_valid}, 32'd1);
            chk("bp_data", {16'd0, o_rsp_data}, 32'd2);
            chk("bp_rdy_low", {31'd0, o_cmd_ready}, 32'd0);
            chk("bp_no_load", {30'd0, o_setup}, 32'd0);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        chk("bp_valid_clr", {31'd0, o_rsp_valid}, 32'd0);
        chk("bp_rdy_back", {31'd0, o_cmd_ready}, 32'd1);
        tick();
        i_cmd_valid = 1'b0;
        chk("bp_load_taken", {30'd0, o_setup}, 32'd2);
        tick();
        chk("bp_load_done", {30'd0, o_setup}, 32'd0);
        do_read("bp_after", 16'd0);

        // zero load value is forwarded
        do_load(2'b11, 16'd9);
        do_read("z_v9", 16'd9);
        do_load(2'b11, 16'd0);
        do_read("z_v0", 16'd0);
        step();
        do_read("z_wrap", 16'd0);

        // reset asserted while LOAD is driving the bus
        send_cmd(2'b10, 16'hA5A5);
        chk("rl_setup", {30'd0, o_setup}, 32'd2);
        chk("rl_bus", {16'd0, io_value}, 32'h0000A5A5);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rl_setup0", {30'd0, o_setup}, 32'd0);
        chk("rl_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rl_rdy", {31'd0, o_cmd_ready}, 32'd1);
        // An undriven bus reads as Z, or as 0 on a two-state simulator;
        // either way the host's load value must be gone.
        chk("rl_bus_released", {31'd0, (io_value === 16'hA5A5)}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        do_read("rl_after", 16'd0);

`ifdef COUNTER_HOST_MATCH_CNT_EN
        // load-inc 1 keeps i_match high at value 0: count saturates at 3
        do_load(2'b10, 16'd1);
        repeat (6) tick();
        chk("mc_sat", {30'd0, o_match_cnt}, 32'd3);
        send_cmd(2'b10, 16'd1);
        chk("mc_clear", {30'd0, o_match_cnt}, 32'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
